// File: rtl/psum_accum_array_pkg.sv
// Shared definitions for the multi-channel partial-sum accumulator:
// default geometry, FSM state encoding and output saturation bounds.
package psum_accum_array_pkg;

    localparam int DEF_N_CH   = 4;
    localparam int DEF_W_IN   = 20;
    localparam int DEF_W_ACC  = 32;
    localparam int DEF_W_BIAS = 16;
    localparam int DEF_W_OUT  = 16;
    localparam int DEF_R_LOG  = 4;

    localparam logic [1:0] ST_ACC = 2'd0;
    localparam logic [1:0] ST_FIN = 2'd1;
    localparam logic [1:0] ST_OUT = 2'd2;

    typedef enum logic [1:0] {
        STATE_ACC = ST_ACC,
        STATE_FIN = ST_FIN,
        STATE_OUT = ST_OUT
    } state_t;

    // Largest value representable in a signed field of width w.
    function automatic logic signed [63:0] sat_hi(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed field of width w.
    function automatic logic signed [63:0] sat_lo(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/psum_accum_array_if.sv
// Beat input, finalisation controls and result handshake of the
// partial-sum accumulator. The slave side is the accumulator itself.
interface psum_accum_array_if
    import psum_accum_array_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int W_IN   = DEF_W_IN,
    parameter int W_BIAS = DEF_W_BIAS,
    parameter int W_OUT  = DEF_W_OUT
) ();

    logic                     i_Vld;
    logic                     o_Rdy;
    logic                     i_First;
    logic                     i_Last;
    logic [N_CH*W_IN-1:0]     i_PSUM;
    logic                     i_Sel_Bias;
    logic                     i_Shift_En;
    logic [N_CH*W_BIAS-1:0]   i_Bias;
    logic                     o_Vld;
    logic                     i_Rdy;
    logic [N_CH*W_OUT-1:0]    o_PSUM;
    logic [N_CH-1:0]          o_Sat;
    logic                     o_Ovf;

    modport slave (
        input  i_Vld, i_First, i_Last, i_PSUM, i_Sel_Bias, i_Shift_En, i_Bias, i_Rdy,
        output o_Rdy, o_Vld, o_PSUM, o_Sat, o_Ovf
    );

    modport master (
        output i_Vld, i_First, i_Last, i_PSUM, i_Sel_Bias, i_Shift_En, i_Bias, i_Rdy,
        input  o_Rdy, o_Vld, o_PSUM, o_Sat, o_Ovf
    );

endinterface

// File: rtl/psum_accum_lane.sv
// Finalisation datapath for one channel: optional round-toward-zero
// right shift, optional bias add, then saturation to the output width.
module psum_accum_lane
    import psum_accum_array_pkg::*;
#(
    parameter int W_ACC  = DEF_W_ACC,
    parameter int W_BIAS = DEF_W_BIAS,
    parameter int W_OUT  = DEF_W_OUT,
    parameter int R_LOG  = DEF_R_LOG
) (
    input  logic signed [W_ACC-1:0]  acc,
    input  logic signed [W_BIAS-1:0] bias,
    input  logic                     shift_en,
    input  logic                     sel_bias,
    output logic signed [W_OUT-1:0]  res,
    output logic                     sat
);

    logic signed [W_ACC-1:0] shifted_s;
    logic signed [W_ACC:0]   biased_s;
    logic signed [63:0]      wide_s;

    generate
        if (R_LOG > 0) begin : g_shift
            logic signed [W_ACC-1:0] shr_s;
            logic                    round_s;

            // Arithmetic shift kept in its own signed net so the sign fill survives.
            assign shr_s   = acc >>> R_LOG;
            // Floor plus one on negative values with discarded bits gives truncation toward zero.
            assign round_s = acc[W_ACC-1] & (acc[R_LOG-1:0] != {R_LOG{1'b0}});

            // Select shifted or raw accumulator.
            always_comb begin
                if (shift_en) begin
                    shifted_s = shr_s + {{(W_ACC-1){1'b0}}, round_s};
                end else begin
                    shifted_s = acc;
                end
            end
        end else begin : g_noshift
            assign shifted_s = acc;
        end
    endgenerate

    // One extra bit of headroom so the bias add itself never wraps.
    always_comb begin
        if (sel_bias) begin
            biased_s = {shifted_s[W_ACC-1], shifted_s}
                     + {{(W_ACC+1-W_BIAS){bias[W_BIAS-1]}}, bias};
        end else begin
            biased_s = {shifted_s[W_ACC-1], shifted_s};
        end
    end

    assign wide_s = 64'(biased_s);

    // Clip to the signed output range and flag any clipping.
    always_comb begin
        if (wide_s > sat_hi(W_OUT)) begin
            res = {1'b0, {(W_OUT-1){1'b1}}};
            sat = 1'b1;
        end else if (wide_s < sat_lo(W_OUT)) begin
            res = {1'b1, {(W_OUT-1){1'b0}}};
            sat = 1'b1;
        end else begin
            res = biased_s[W_OUT-1:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/psum_accum_array.sv
// N-channel signed partial-sum accumulator. Beats are summed per channel
// until a last-flagged beat, then one finalisation cycle shifts, biases
// and saturates every channel into a held valid/ready output register.
module psum_accum_array
    import psum_accum_array_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int W_IN   = DEF_W_IN,
    parameter int W_ACC  = DEF_W_ACC,
    parameter int W_BIAS = DEF_W_BIAS,
    parameter int W_OUT  = DEF_W_OUT,
    parameter int R_LOG  = DEF_R_LOG
) (
    input  logic               i_CLK,
    input  logic               i_RSTb,
    psum_accum_array_if.slave  bus
);

    state_t                  state_r;
    state_t                  state_s;
    logic                    rdy_r;
    logic                    vld_r;
    logic                    ovf_r;
    logic                    sel_bias_r;
    logic                    shift_en_r;
    logic [N_CH*W_BIAS-1:0]  bias_r;
    logic [N_CH*W_OUT-1:0]   psum_r;
    logic [N_CH*W_OUT-1:0]   res_s;
    logic [N_CH-1:0]         sat_r;
    logic [N_CH-1:0]         sat_s;
    logic [N_CH-1:0]         lane_ovf_s;
    logic signed [W_ACC-1:0] acc_r     [N_CH];
    logic signed [W_ACC-1:0] acc_sum_s [N_CH];
    logic                    accept_s;
    logic                    out_take_s;

    assign accept_s   = bus.i_Vld & rdy_r & (state_r == STATE_ACC);
    assign out_take_s = vld_r & bus.i_Rdy & (state_r == STATE_OUT);

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            logic signed [W_IN-1:0]  lane_in_s;
            logic signed [W_ACC-1:0] base_s;
            logic signed [W_ACC-1:0] add_s;

            // A first beat starts from zero instead of the retained sum.
            assign lane_in_s     = bus.i_PSUM[g*W_IN +: W_IN];
            assign base_s        = bus.i_First ? {W_ACC{1'b0}} : acc_r[g];
            assign add_s         = W_ACC'(lane_in_s);
            assign acc_sum_s[g]  = base_s + add_s;
            // Signed wrap: operands agree in sign but the sum does not.
            assign lane_ovf_s[g] = (base_s[W_ACC-1] == add_s[W_ACC-1])
                                 & (acc_sum_s[g][W_ACC-1] != base_s[W_ACC-1]);

            psum_accum_lane #(
                .W_ACC  (W_ACC),
                .W_BIAS (W_BIAS),
                .W_OUT  (W_OUT),
                .R_LOG  (R_LOG)
            ) u_lane (
                .acc      (acc_r[g]),
                .bias     (bias_r[g*W_BIAS +: W_BIAS]),
                .shift_en (shift_en_r),
                .sel_bias (sel_bias_r),
                .res      (res_s[g*W_OUT +: W_OUT]),
                .sat      (sat_s[g])
            );
        end
    endgenerate

    // Next-state decode for the accumulate / finalise / output sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            STATE_ACC: begin
                if (accept_s && bus.i_Last) begin
                    state_s = STATE_FIN;
                end else begin
                    state_s = STATE_ACC;
                end
            end
            STATE_FIN: begin
                state_s = STATE_OUT;
            end
            STATE_OUT: begin
                if (out_take_s) begin
                    state_s = STATE_ACC;
                end else begin
                    state_s = STATE_OUT;
                end
            end
            default: begin
                state_s = STATE_ACC;
            end
        endcase
    end

    // State register; ready is registered from the next state so it tracks ACC exactly.
    always_ff @(posedge i_CLK or negedge i_RSTb) begin
        if (!i_RSTb) begin
            state_r <= STATE_ACC;
            rdy_r   <= 1'b1;
        end else begin
            state_r <= state_s;
            rdy_r   <= (state_s == STATE_ACC);
        end
    end

    // Per-channel accumulators; contents survive a finished tile for split tiles.
    always_ff @(posedge i_CLK or negedge i_RSTb) begin
        if (!i_RSTb) begin
            for (int c = 0; c < N_CH; c++) begin
                acc_r[c] <= {W_ACC{1'b0}};
            end
        end else if (accept_s) begin
            for (int c = 0; c < N_CH; c++) begin
                acc_r[c] <= acc_sum_s[c];
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                acc_r[c] <= acc_r[c];
            end
        end
    end

    // Sticky wrap flag, restarted by a first beat and re-evaluated on that beat.
    always_ff @(posedge i_CLK or negedge i_RSTb) begin
        if (!i_RSTb) begin
            ovf_r <= 1'b0;
        end else if (accept_s) begin
            ovf_r <= (bus.i_First ? 1'b0 : ovf_r) | (|lane_ovf_s);
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Capture finalisation controls with the last beat of a tile.
    always_ff @(posedge i_CLK or negedge i_RSTb) begin
        if (!i_RSTb) begin
            bias_r     <= {(N_CH*W_BIAS){1'b0}};
            sel_bias_r <= 1'b0;
            shift_en_r <= 1'b0;
        end else if (accept_s && bus.i_Last) begin
            bias_r     <= bus.i_Bias;
            sel_bias_r <= bus.i_Sel_Bias;
            shift_en_r <= bus.i_Shift_En;
        end else begin
            bias_r     <= bias_r;
            sel_bias_r <= sel_bias_r;
            shift_en_r <= shift_en_r;
        end
    end

    // Result register: loaded in FIN, held through OUT until taken.
    always_ff @(posedge i_CLK or negedge i_RSTb) begin
        if (!i_RSTb) begin
            psum_r <= {(N_CH*W_OUT){1'b0}};
            sat_r  <= {N_CH{1'b0}};
            vld_r  <= 1'b0;
        end else if (state_r == STATE_FIN) begin
            psum_r <= res_s;
            sat_r  <= sat_s;
            vld_r  <= 1'b1;
        end else if (out_take_s) begin
            psum_r <= psum_r;
            sat_r  <= sat_r;
            vld_r  <= 1'b0;
        end else begin
            psum_r <= psum_r;
            sat_r  <= sat_r;
            vld_r  <= vld_r;
        end
    end

    assign bus.o_Rdy  = rdy_r;
    assign bus.o_Vld  = vld_r;
    assign bus.o_PSUM = psum_r;
    assign bus.o_Sat  = sat_r;
    assign bus.o_Ovf  = ovf_r;

endmodule

// File: tb/tb_psum_accum_array.sv
// Directed bench for psum_accum_array with hand-computed expectations.
module tb_psum_accum_array;
    import psum_accum_array_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    psum_accum_array_if bus ();

    psum_accum_array u_dut (
        .i_CLK  (clk),
        .i_RSTb (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic signed [15:0] out_lane(input int c);
        return bus.o_PSUM[c*16 +: 16];
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int e0, input int e1,
                           input int e2, input int e3, input logic [3:0] esat);
        check({tag, "_vld"}, 64'(bus.o_Vld), 64'(1'b1));
        check({tag, "_l0"}, 64'(out_lane(0)), 64'(e0));
        check({tag, "_l1"}, 64'(out_lane(1)), 64'(e1));
        check({tag, "_l2"}, 64'(out_lane(2)), 64'(e2));
        check({tag, "_l3"}, 64'(out_lane(3)), 64'(e3));
        check({tag, "_sat"}, 64'(bus.o_Sat), 64'(esat));
    endtask

    // Offer one beat at a falling edge once ready, return one cycle later.
    task automatic beat(input logic first, input logic last,
                        input int p0, input int p1, input int p2, input int p3,
                        input logic sel, input logic shen,
                        input int b0, input int b1, input int b2, input int b3);
        int n;
        n = 0;
        while (bus.o_Rdy !== 1'b1 && n < 32) begin
            @(negedge clk);
            n++;
        end
        if (n >= 32) begin
            vectors++;
            miscompares++;
            $error("FAIL beat_rdy_timeout observed=0 expected=1");
        end
        bus.i_First    = first;
        bus.i_Last     = last;
        bus.i_PSUM     = {20'(p3), 20'(p2), 20'(p1), 20'(p0)};
        bus.i_Sel_Bias = sel;
        bus.i_Shift_En = shen;
        bus.i_Bias     = {16'(b3), 16'(b2), 16'(b1), 16'(b0)};
        bus.i_Vld      = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.i_Vld   = 1'b0;
        bus.i_First = 1'b0;
        bus.i_Last  = 1'b0;
    endtask

    task automatic take(input string tag);
        bus.i_Rdy = 1'b1;
        @(negedge clk);
        bus.i_Rdy = 1'b0;
        check({tag, "_take_vld"}, 64'(bus.o_Vld), 64'(1'b0));
        check({tag, "_take_rdy"}, 64'(bus.o_Rdy), 64'(1'b1));
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        bus.i_Vld      = 1'b0;
        bus.i_First    = 1'b0;
        bus.i_Last     = 1'b0;
        bus.i_PSUM     = '0;
        bus.i_Sel_Bias = 1'b0;
        bus.i_Shift_En = 1'b0;
        bus.i_Bias     = '0;
        bus.i_Rdy      = 1'b0;

        // Reset state
        #12;
        check("rst_vld", 64'(bus.o_Vld), 64'(1'b0));
        check("rst_psum", 64'(bus.o_PSUM), 64'(0));
        check("rst_sat", 64'(bus.o_Sat), 64'(0));
        check("rst_ovf", 64'(bus.o_Ovf), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_rdy", 64'(bus.o_Rdy), 64'(1'b1));

        // Three-beat tile: 100 - 30 + 5 = 75
        beat(1'b1, 1'b0, 100, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);
        beat(1'b0, 1'b0, -30, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);
        beat(1'b0, 1'b1, 5, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);
        idle();
        check("t1_fin_vld", 64'(bus.o_Vld), 64'(1'b0));
        check("t1_fin_rdy", 64'(bus.o_Rdy), 64'(1'b0));
        @(negedge clk);
        chk_out("t1", 75, 0, 0, 0, 4'b0000);
        check("t1_ovf", 64'(bus.o_Ovf), 64'(1'b0));
        take("t1");

        // One-beat tile with rounding shift and bias
        beat(1'b1, 1'b1, -17, 40, 0, 0, 1'b1, 1'b1, 3, 3, 0, 0);
        idle();
        @(negedge clk);
        chk_out("t2", 2, 5, 0, 0, 4'b0000);
        take("t2");

        // Saturation at both ends, plus exact bounds that must not clip
        beat(1'b1, 1'b1, 70000, -70000, 32767, -32768, 1'b0, 1'b0, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        chk_out("t3", 32767, -32768, 32767, -32768, 4'b0011);

        // Backpressure: output held, a competing beat is not accepted
        bus.i_First = 1'b1;
        bus.i_Last  = 1'b1;
        bus.i_PSUM  = {20'(0), 20'(0), 20'(0), 20'(999)};
        bus.i_Vld   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rdy", 64'(bus.o_Rdy), 64'(1'b0));
            chk_out("bp", 32767, -32768, 32767, -32768, 4'b0011);
        end
        idle();
        take("t3");

        // Split tile onto retained sums: 70000-69990, -70000+69990, 32767+1
        beat(1'b0, 1'b1, -69990, 69990, 1, 0, 1'b0, 1'b0, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        chk_out("t4", 10, -10, 32767, -32768, 4'b0100);
        take("t4");

        // Overflow: 4096 beats of -2^19 reach -2^31 exactly, then -1 wraps
        beat(1'b1, 1'b0, -524288, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 4095; i++) begin
            beat(1'b0, 1'b0, -524288, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);
        end
        check("ovf_edge_clear", 64'(bus.o_Ovf), 64'(1'b0));
        beat(1'b0, 1'b0, -1, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);
        check("ovf_set", 64'(bus.o_Ovf), 64'(1'b1));
        beat(1'b0, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);
        idle();
        check("ovf_fin", 64'(bus.o_Ovf), 64'(1'b1));
        @(negedge clk);
        chk_out("t5", 32767, 0, 0, 0, 4'b0001);
        check("ovf_out", 64'(bus.o_Ovf), 64'(1'b1));
        take("t5");
        check("ovf_sticky", 64'(bus.o_Ovf), 64'(1'b1));
        beat(1'b1, 1'b1, 7, 1, 2, 3, 1'b0, 1'b0, 0, 0, 0, 0);
        idle();
        check("ovf_first_clr", 64'(bus.o_Ovf), 64'(1'b0));
        @(negedge clk);
        chk_out("t6", 7, 1, 2, 3, 4'b0000);
        take("t6");

        // Reset while the result is held drops it immediately
        beat(1'b1, 1'b1, 5, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        check("rm_pre_vld", 64'(bus.o_Vld), 64'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_vld", 64'(bus.o_Vld), 64'(1'b0));
        check("rm_psum", 64'(bus.o_PSUM), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rm_rdy", 64'(bus.o_Rdy), 64'(1'b1));
        beat(1'b1, 1'b1, 7, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        chk_out("t7", 7, 0, 0, 0, 4'b0000);
        take("t7");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
